// File: rtl/nand_result_fifo_if.sv
// Result-pair handshake bundle: upstream push side and downstream show-ahead
// pop side of the NAND result FIFO.
interface nand_result_fifo_if #(
  parameter int DATA_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_scalar;
  logic [DATA_W-1:0] in_vector;
  logic              out_valid;
  logic              out_ready;
  logic              out_scalar;
  logic [DATA_W-1:0] out_vector;

  // Producer/consumer side (drives data in, takes data out)
  modport master (
    output in_valid, in_scalar, in_vector, out_ready,
    input  in_ready, out_valid, out_scalar, out_vector
  );

  // FIFO side
  modport slave (
    input  in_valid, in_scalar, in_vector, out_ready,
    output in_ready, out_valid, out_scalar, out_vector
  );
endinterface

// File: rtl/nand_result_fifo.sv
// Show-ahead synchronous FIFO for scalar/vector NAND result pairs, with
// accepted (wrapping) and dropped (saturating) statistics counters.
module nand_result_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nand_result_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         accept_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Scalar kept in the MSB so a pair is always written and read as one word
  logic [DATA_W:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DATA_W:0]  head;
  logic             push;
  logic             pop;
  logic             drop;

  // Status decodes come from registered level only, so no input reaches an output
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;

  // No pass-through when full: a same-cycle pop does not open a push slot
  assign push = bus.in_valid & ~full;
  assign pop  = bus.out_ready & ~empty;
  assign drop = bus.in_valid & full;

  assign head           = mem[rd_ptr];
  assign bus.out_scalar = empty ? 1'b0 : head[DATA_W];
  assign bus.out_vector = empty ? '0 : head[DATA_W-1:0];

  // Pointer, occupancy and statistics registers; reset wins over push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        accept_cnt <= accept_cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
      if (drop && !(&drop_cnt)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  // Storage array is not reset; the write is suppressed during reset anyway
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= {bus.in_scalar, bus.in_vector};
    end
  end
endmodule

// File: tb/tb_nand_result_fifo.sv
// Randomized + directed bench for nand_result_fifo: a queue-based reference
// model feeds a scoreboard that a negedge monitor drains as the DUT pops.
module tb_nand_result_fifo;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  logic [$clog2(DEPTH):0] level;
  logic full, empty;
  logic [CNT_W-1:0] accept_cnt, drop_cnt;

  nand_result_fifo_if #(.DATA_W(DATA_W)) bus ();

  nand_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .level(level), .full(full),
    .empty(empty), .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  // Reference model: expected contents as a queue of {scalar,vector} words
  logic [DATA_W:0] sb_q[$];
  int m_level = 0;
  int m_acc = 0;
  int m_drop = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit p, q;
    if (!rst_n) begin
      sb_q.delete();
      m_level = 0;
      m_acc = 0;
      m_drop = 0;
    end else begin
      p = bus.in_valid && (m_level < DEPTH);
      q = bus.out_ready && (m_level > 0);
      if (p) begin
        sb_q.push_back({bus.in_scalar, bus.in_vector});
        m_acc = (m_acc + 1) % (CNT_MAX + 1);
      end
      if (bus.in_valid && m_level == DEPTH && m_drop < CNT_MAX) m_drop = m_drop + 1;
      m_level = m_level + int'(p) - int'(q);
    end
  end

  // Monitor: compare status every cycle, pop the scoreboard on each DUT pop
  always @(negedge clk) begin
    if (mon_on) begin
      chk("level", int'(level), m_level);
      chk("full", int'(full), int'(m_level == DEPTH));
      chk("empty", int'(empty), int'(m_level == 0));
      chk("in_ready", int'(bus.in_ready), int'(m_level != DEPTH));
      chk("out_valid", int'(bus.out_valid), int'(m_level != 0));
      chk("accept_cnt", int'(accept_cnt), m_acc);
      chk("drop_cnt", int'(drop_cnt), m_drop);
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("out_data", int'({bus.out_scalar, bus.out_vector}), int'(sb_q[0]));
          if (bus.out_ready && rst_n) void'(sb_q.pop_front());
        end
      end else begin
        chk("out_zero_when_empty", int'({bus.out_scalar, bus.out_vector}), 0);
      end
    end
  end

  // Apply inputs (called at posedge+1), then advance past the next edge
  task automatic cyc(input bit v, input bit s, input logic [3:0] vec, input bit r);
    bus.in_valid  = v;
    bus.in_scalar = s;
    bus.in_vector = vec;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_before, drop_before;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_scalar = 1'b0;
    bus.in_vector = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_out_vector", int'(bus.out_vector), 0);
    chk("rst_accept", int'(accept_cnt), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    rst_n = 1'b1;
    mon_on = 1'b1;

    // Single pass
    cyc(1, 1, 4'hA, 0);
    chk("sp_out_valid", int'(bus.out_valid), 1);
    chk("sp_out_scalar", int'(bus.out_scalar), 1);
    chk("sp_out_vector", int'(bus.out_vector), 'hA);
    chk("sp_level", int'(level), 1);
    cyc(0, 0, 4'h0, 1);
    chk("sp_empty", int'(empty), 1);
    chk("sp_accept", int'(accept_cnt), 1);
    cyc(0, 0, 4'h0, 0);

    // Fill and drop
    for (int i = 1; i <= 4; i++) cyc(1, i[0], 4'(i), 0);
    chk("fill_full", int'(full), 1);
    chk("fill_in_ready", int'(bus.in_ready), 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 4'hF, 0);
    chk("fill_drop3", int'(drop_cnt), 3);
    chk("fill_level", int'(level), 4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", int'(bus.out_vector), i);
      cyc(0, 0, 4'h0, 1);
    end
    chk("drain_empty", int'(empty), 1);

    // Simultaneous push/pop at level 2, six times to wrap the pointers
    cyc(1, 0, 4'h5, 0);
    cyc(1, 1, 4'h6, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, i[0], 4'(7 + i), 1);
      chk("pp_level2", int'(level), 2);
    end
    chk("pp_head", int'(bus.out_vector), 'hB);
    cyc(0, 0, 4'h0, 1);
    chk("pp_last", int'(bus.out_vector), 'hC);
    cyc(0, 0, 4'h0, 1);

    // Pop while full: no push slot opens
    for (int i = 0; i < 4; i++) cyc(1, 1, 4'(i + 2), 0);
    acc_before = int'(accept_cnt);
    drop_before = int'(drop_cnt);
    cyc(1, 0, 4'h9, 1);
    chk("fp_level", int'(level), 3);
    chk("fp_accept", int'(accept_cnt), acc_before);
    chk("fp_drop", int'(drop_cnt), drop_before + 1);

    // Reset mid-operation with push and pop both active
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_vector = 4'hE;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mr_level", int'(level), 0);
    chk("mr_out_valid", int'(bus.out_valid), 0);
    chk("mr_accept", int'(accept_cnt), 0);
    chk("mr_drop", int'(drop_cnt), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'h0, 1);
    chk("mr_no_stale", int'(bus.out_valid), 0);

    // Random traffic long enough to wrap accept_cnt
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 60), 1'($urandom), 4'($urandom), ($urandom_range(0, 99) < 45));
    end

    // Saturate drop_cnt
    for (int i = 0; i < 300; i++) cyc(1, 1'($urandom), 4'($urandom), 0);
    chk("drop_sat", int'(drop_cnt), CNT_MAX);
    for (int i = 0; i < 6; i++) cyc(0, 0, 4'h0, 1);
    chk("final_empty", int'(empty), 1);

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
